// File: rtl/prach_hb4_interp.sv
// prach_hb4_interp: 2x halfband interpolator for TDM-interleaved PRACH samples.
// Each accepted input yields a phase pair: dp1 is the center-tap passthrough, and
// dp2 is the symmetric 8-tap FIR phase. Channels share one delay line whose
// stride equals the number of channel slots, so tap k of a channel sits at
// x[k*NumChannelUsed]. The datapath is a fixed 6-register pipeline. Latency
// must equal that depth so the sideband stays aligned with the data.
module prach_hb4_interp #(
    parameter int NumChannelUsed = 48,
    parameter int Latency        = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] din_dq,
    input  logic               din_dv,
    input  logic [7:0]         din_chn,
    input  logic               sync_in,
    output logic signed [15:0] dout_dp1,
    output logic signed [15:0] dout_dp2,
    output logic               dout_dv,
    output logic [7:0]         dout_chn,
    output logic               sync_out
);

    localparam int DlLen = 7 * NumChannelUsed + 1;

    // Coefficients for the symmetric pairs (0,7), (1,6), (2,5), (3,4).
    localparam logic signed [17:0] Coef [4] = '{-18'sd669, 18'sd3099, -18'sd9939, 18'sd40231};

    // Round half up at bit 16, then clamp to the 16-bit output range.
    function automatic logic signed [15:0] round_sat(input logic signed [36:0] s);
        logic signed [37:0] r;
        logic signed [21:0] q;
        r = $signed({s[36], s}) + 38'sd32768;
        q = $signed(r[37:16]);
        if (q > 22'sd32767)
            return 16'sd32767;
        else if (q < -22'sd32768)
            return -16'sd32768;
        else
            return q[15:0];
    endfunction

    logic signed [15:0] x_q [DlLen];
    logic signed [15:0] tap_p1_q [8];
    logic signed [16:0] pre_p2_d [4];
    logic signed [16:0] pre_p2_q [4];
    logic signed [15:0] ctr_p2_q;
    logic signed [34:0] prod_p3_d [4];
    logic signed [34:0] prod_p3_q [4];
    logic signed [15:0] ctr_p3_q;
    logic signed [36:0] sum_p4_d;
    logic signed [36:0] sum_p4_q;
    logic signed [15:0] ctr_p4_q;
    logic signed [15:0] dp1_q;
    logic signed [15:0] dp2_q;
    logic [Latency-1:0] dv_sr_q;
    logic [Latency-1:0] sync_sr_q;
    logic [7:0]         chn_sr_q [Latency];

    // Stage 1: shared delay line, advanced only by accepted samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DlLen; i++) x_q[i] <= '0;
        end else if (din_dv) begin
            x_q[0] <= din_dq;
            for (int i = 1; i < DlLen; i++) x_q[i] <= x_q[i-1];
        end
    end

    // Pre-add symmetric tap pairs at full 17-bit width.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            pre_p2_d[j] = '0;
            pre_p2_d[j] = $signed({tap_p1_q[j][15], tap_p1_q[j]})
                        + $signed({tap_p1_q[7-j][15], tap_p1_q[7-j]});
        end
    end

    // Multiply each pre-added pair by its coefficient (17x18 -> 35 bits).
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            prod_p3_d[j] = '0;
            prod_p3_d[j] = pre_p2_q[j] * Coef[j];
        end
    end

    // Sum the four products at 37 bits with no truncation.
    always_comb begin
        sum_p4_d = '0;
        for (int j = 0; j < 4; j++) begin
            sum_p4_d = sum_p4_d + $signed({{2{prod_p3_q[j][34]}}, prod_p3_q[j]});
        end
    end

    // Stages 2-5: tap capture, pre-add, multiply, adder tree; center tap rides along.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) tap_p1_q[k] <= '0;
            for (int j = 0; j < 4; j++) begin
                pre_p2_q[j]  <= '0;
                prod_p3_q[j] <= '0;
            end
            ctr_p2_q <= '0;
            ctr_p3_q <= '0;
            ctr_p4_q <= '0;
            sum_p4_q <= '0;
        end else begin
            for (int k = 0; k < 8; k++) tap_p1_q[k] <= x_q[k*NumChannelUsed];
            for (int j = 0; j < 4; j++) begin
                pre_p2_q[j]  <= pre_p2_d[j];
                prod_p3_q[j] <= prod_p3_d[j];
            end
            ctr_p2_q <= tap_p1_q[3];
            ctr_p3_q <= ctr_p2_q;
            ctr_p4_q <= ctr_p3_q;
            sum_p4_q <= sum_p4_d;
        end
    end

    // Stage 6: output register, loaded only for valid samples so gaps hold values.
    always_ff @(posedge clk) begin
        if (rst) begin
            dp1_q <= '0;
            dp2_q <= '0;
        end else if (dv_sr_q[Latency-2]) begin
            dp1_q <= ctr_p4_q;
            dp2_q <= round_sat(sum_p4_q);
        end
    end

    // Sideband delay: dv, channel and sync travel Latency cycles alongside the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            dv_sr_q   <= '0;
            sync_sr_q <= '0;
            for (int i = 0; i < Latency; i++) chn_sr_q[i] <= '0;
        end else begin
            dv_sr_q     <= {dv_sr_q[Latency-2:0], din_dv};
            sync_sr_q   <= {sync_sr_q[Latency-2:0], sync_in};
            chn_sr_q[0] <= din_chn;
            for (int i = 1; i < Latency; i++) chn_sr_q[i] <= chn_sr_q[i-1];
        end
    end

    assign dout_dp1 = dp1_q;
    assign dout_dp2 = dp2_q;
    assign dout_dv  = dv_sr_q[Latency-1];
    assign dout_chn = chn_sr_q[Latency-1];
    assign sync_out = sync_sr_q[Latency-1];

endmodule
